// File: rtl/weight_bank.sv
// weight_bank: bank of N signed weights with sequenced init, indexed delta updates and epoch counting; saturation when WEIGHT_BANK_SAT_EN is defined
module weight_bank #(
  parameter int N = 4,
  parameter int DW = 16,
  parameter int FRAC = 10,
  parameter logic signed [DW-1:0] INIT_VAL = 16'sd102,
  localparam int IDXW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init_start,
  output logic                   init_busy,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [IDXW-1:0]        upd_idx,
  input  logic signed [DW-1:0]   upd_delta,
  input  logic                   upd_last,
  input  logic [IDXW-1:0]        rd_idx,
  output logic signed [DW-1:0]   rd_w,
  output logic [N*DW-1:0]        w_flat,
  output logic [15:0]            epoch_cnt,
  output logic                   err_idx,
  output logic                   sat_flag
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] INIT = 1'b1;
  if (FRAC > DW - 1) begin : g_bad_frac
    $error("FRAC must leave room for the sign bit");
  end
  logic [0:0] state_q, state_d;
  logic [IDXW-1:0] k_q, k_d;
  logic signed [DW-1:0] w_q [N];
  logic signed [DW-1:0] w_d [N];
  logic signed [DW-1:0] rd_q, rd_d, w_sel, res;
  logic [DW:0] sum;
  logic [15:0] epoch_q, epoch_d;
  logic err_q, err_d, sat_q, sat_d, hs, start, ovf;
  assign upd_ready = (state_q == IDLE) && !init_start;
  assign hs = upd_valid && upd_ready;
  assign start = (state_q == IDLE) && init_start;
  assign init_busy = (state_q == INIT);
  assign rd_w = rd_q;
  assign epoch_cnt = epoch_q;
  assign err_idx = err_q;
  assign sat_flag = sat_q;
  for (genvar i = 0; i < N; i++) begin : g_flat
    assign w_flat[i*DW +: DW] = w_q[i];
  end
  // operand selection, widened add with overflow detection, and next-state for the whole bank
  always_comb begin
    w_sel = '0;
    rd_d = '0;
    for (int i = 0; i < N; i++) begin
      if (upd_idx == IDXW'(i)) w_sel = w_q[i];
      if (rd_idx == IDXW'(i)) rd_d = w_q[i];
    end
    sum = {w_sel[DW-1], w_sel} + {upd_delta[DW-1], upd_delta};
    ovf = sum[DW] ^ sum[DW-1];
`ifdef WEIGHT_BANK_SAT_EN
    res = ovf ? (sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : sum[DW-1:0];
`else
    res = sum[DW-1:0];
`endif
    for (int i = 0; i < N; i++)
      w_d[i] = (state_q == INIT && k_q == IDXW'(i)) ? INIT_VAL :
               (hs && upd_idx == IDXW'(i)) ? res : w_q[i];
    state_d = start ? INIT : (state_q == INIT && k_q == IDXW'(N-1)) ? IDLE : state_q;
    k_d = (state_q == INIT) ? k_q + 1'b1 : '0;
    epoch_d = epoch_q + 16'(hs && upd_last);
    err_d = start ? 1'b0 : err_q | (hs && int'(upd_idx) >= N);
    sat_d = start ? 1'b0 : sat_q | (hs && ovf);
  end
  // state registers; reset abandons any init in progress and zeroes the bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      w_q <= '{default: '0};
      rd_q <= '0;
      epoch_q <= '0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      w_q <= w_d;
      rd_q <= rd_d;
      epoch_q <= epoch_d;
      err_q <= err_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_weight_bank.sv
// tb_weight_bank: directed checks of init, updates, overflow, bad index and read path on N=4 and N=3 banks
module tb_weight_bank;
  logic clk = 1'b0, reset = 1'b1, init_start = 1'b0, upd_valid = 1'b0, upd_last = 1'b0;
  logic [1:0] upd_idx = '0, rd_idx = '0;
  logic signed [15:0] upd_delta = '0;
  logic busy4, ready4, err4, sat4, busy3, ready3, err3, sat3;
  logic signed [15:0] rd4, rd3;
  logic [63:0] flat4;
  logic [47:0] flat3;
  logic [15:0] ep4, ep3;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  weight_bank #(.N(4)) d4 (.clk(clk), .reset(reset), .init_start(init_start), .init_busy(busy4),
    .upd_valid(upd_valid), .upd_ready(ready4), .upd_idx(upd_idx), .upd_delta(upd_delta),
    .upd_last(upd_last), .rd_idx(rd_idx), .rd_w(rd4), .w_flat(flat4), .epoch_cnt(ep4),
    .err_idx(err4), .sat_flag(sat4));
  weight_bank #(.N(3)) d3 (.clk(clk), .reset(reset), .init_start(init_start), .init_busy(busy3),
    .upd_valid(upd_valid), .upd_ready(ready3), .upd_idx(upd_idx), .upd_delta(upd_delta),
    .upd_last(upd_last), .rd_idx(rd_idx), .rd_w(rd3), .w_flat(flat3), .epoch_cnt(ep3),
    .err_idx(err3), .sat_flag(sat3));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic hs(input logic [1:0] idx, input logic signed [15:0] d, input logic last);
    upd_valid = 1'b1; upd_idx = idx; upd_delta = d; upd_last = last;
    @(negedge clk);
    upd_valid = 1'b0; upd_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy4 && n < 20) begin n++; @(negedge clk); end
    chk("init_done", 64'(busy4), 64'd0);
  endtask

  task automatic do_init();
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_flat", flat4, 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_epoch", 64'(ep4), 64'd0);
    chk("rst_flags", {62'd0, err4, sat4}, 64'd0);
    chk("rst_rd", 64'(rd4), 64'd0);
    chk("rst_ready", 64'(ready4), 64'd1);
    // reset mid-init
    init_start = 1'b1;
    #1 chk("start_ready", 64'(ready4), 64'd0);
    @(negedge clk);
    init_start = 1'b0;
    chk("init_busy_on", 64'(busy4), 64'd1);
    repeat (2) @(negedge clk);
    chk("mid_init_w0", 64'(flat4[15:0]), 64'h66);
    reset = 1'b1;
    #1 chk("mid_rst_flat", flat4, 64'd0);
    chk("mid_rst_busy", 64'(busy4), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    n = 0;
    while (busy4 && n < 20) begin n++; @(negedge clk); end
    chk("busy_cycles", 64'(n), 64'd4);
    chk("init_flat4", flat4, 64'h0066_0066_0066_0066);
    chk("init_flat3", 64'(flat3), 64'h0066_0066_0066);
    // back-to-back updates on one index
    upd_valid = 1'b1; upd_idx = 2'd1; upd_delta = 16'sd10;
    #1 chk("upd_ready", 64'(ready4), 64'd1);
    @(negedge clk);
    upd_delta = -16'sd3;
    @(negedge clk);
    upd_valid = 1'b0;
    chk("b2b_flat", flat4, 64'h0066_0066_006D_0066);
    chk("b2b_sat", 64'(sat4), 64'd0);
    // read latency
    rd_idx = 2'd2;
    hs(2'd2, 16'sd5, 1'b0);
    chk("w2_flat", flat4, 64'h0066_006B_006D_0066);
    @(negedge clk);
    chk("rd_w2", 64'(rd4), 64'h6B);
    // init beats update
    init_start = 1'b1; upd_valid = 1'b1; upd_idx = 2'd0; upd_delta = 16'sd50;
    #1 chk("collide_ready", 64'(ready4), 64'd0);
    @(negedge clk);
    init_start = 1'b0; upd_valid = 1'b0;
    wait_idle();
    chk("collide_flat", flat4, 64'h0066_0066_0066_0066);
    // overflow
    hs(2'd0, 16'sd32650, 1'b0);
    chk("pre_ovf_w0", 64'(flat4[15:0]), 64'h7FF0);
    chk("pre_ovf_sat", 64'(sat4), 64'd0);
    hs(2'd0, 16'sh0020, 1'b0);
`ifdef WEIGHT_BANK_SAT_EN
    chk("ovf_w0", 64'(flat4[15:0]), 64'h7FFF);
`else
    chk("ovf_w0", 64'(flat4[15:0]), 64'h8010);
`endif
    chk("ovf_sat", 64'(sat4), 64'd1);
    chk("ovf_others", 64'(flat4[63:16]), 64'h0066_0066_0066);
    // out-of-range index on N=3
    do_init();
    chk("init_clr_sat", 64'(sat4), 64'd0);
    hs(2'd3, 16'sd7, 1'b1);
    chk("bad_idx_flat3", 64'(flat3), 64'h0066_0066_0066);
    chk("bad_idx_err3", 64'(err3), 64'd1);
    chk("bad_idx_ep3", 64'(ep3), 64'd1);
    chk("idx3_w3_n4", 64'(flat4[63:48]), 64'h6D);
    chk("idx3_err4", 64'(err4), 64'd0);
    chk("idx3_ep4", 64'(ep4), 64'd1);
    do_init();
    chk("init_clr_err3", 64'(err3), 64'd0);
    chk("init_keep_ep3", 64'(ep3), 64'd1);
    // read beyond N
    rd_idx = 2'd3;
    repeat (2) @(negedge clk);
    chk("rd_oob3", 64'(rd3), 64'd0);
    chk("rd3_n4", 64'(rd4), 64'h66);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
